// File: rtl/ddr_frame_arbiter_pkg.sv
// Shared types for the DDR3 frame arbiter.
// State encoding and app command opcodes.
package ddr_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_CMD,
    WR_DATA,
    RD_CMD,
    RD_WAIT
  } arb_state_e;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  function automatic logic [5:0] burst_num(
    input logic [7:0] len
  );
    logic [7:0] m1;
    m1 = len - 8'd1;
    return m1[5:0];
  endfunction

endpackage

// File: rtl/ddr_frame_arbiter_if.sv
// DDR3 IP app-side command and write-data handshake.
// master = arbiter, slave = memory controller IP.
interface ddr_frame_arbiter_if #(
  parameter int ADDR_W = 29
);

  logic              app_cmd_en;
  logic [2:0]        app_cmd;
  logic [ADDR_W-1:0] app_addr;
  logic [5:0]        app_burst_number;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic              app_cmd_rdy;
  logic              app_wdf_rdy;
  logic              app_rd_data_valid;

  modport master (
    output app_cmd_en,
    output app_cmd,
    output app_addr,
    output app_burst_number,
    output app_wdf_wren,
    output app_wdf_end,
    input  app_cmd_rdy,
    input  app_wdf_rdy,
    input  app_rd_data_valid
  );

  modport slave (
    input  app_cmd_en,
    input  app_cmd,
    input  app_addr,
    input  app_burst_number,
    input  app_wdf_wren,
    input  app_wdf_end,
    output app_cmd_rdy,
    output app_wdf_rdy,
    output app_rd_data_valid
  );

endinterface

// File: rtl/ddr_frame_arbiter_load_sync.sv
// Two-flop synchroniser plus rising-edge detect
// for the asynchronous frame-start levels.
module ddr_load_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], async_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/ddr_frame_arbiter.sv
// Burst arbiter between camera write FIFO and HDMI read FIFO,
// with double-buffered frame pages on the DDR3 app interface.
module ddr_frame_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int ADDR_W      = 29,
  parameter int CNT_W       = 10,
  parameter int ADDR_STEP   = 8,
  parameter logic [ADDR_W-1:0] PAGE_OFS = 'h400000,
  parameter int RD_URGENT   = 64,
  parameter int RFIFO_DEPTH = 512
) (
  input  logic              clk,
  input  logic              sys_rst_n,
  input  logic              init_calib_complete,
  input  logic              wr_load,
  input  logic              rd_load,
  input  logic [ADDR_W-1:0] app_addr_wr_min,
  input  logic [ADDR_W-1:0] app_addr_wr_max,
  input  logic [ADDR_W-1:0] app_addr_rd_min,
  input  logic [ADDR_W-1:0] app_addr_rd_max,
  input  logic [7:0]        wr_burst_len,
  input  logic [7:0]        rd_burst_len,
  input  logic [CNT_W-1:0]  wfifo_cnt,
  input  logic [CNT_W-1:0]  rfifo_cnt,
  output logic              wfifo_rden,
  output logic              wr_page,
  output logic              rd_page,
  ddr_frame_arbiter_if.master app
);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] wr_off_q, wr_off_d;
  logic [ADDR_W-1:0] rd_off_q, rd_off_d;
  logic              wr_page_q, wr_page_d;
  logic              rd_page_q, rd_page_d;
  logic              done_page_q, done_page_d;
  logic              wr_done_q, wr_done_d;
  logic              rd_done_q, rd_done_d;
  logic              wr_pend_q, wr_pend_d;
  logic              rd_pend_q, rd_pend_d;
  logic              last_rd_q, last_rd_d;
  logic [2:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [5:0]        bn_q, bn_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        beat_q, beat_d;

  logic              wr_pulse, rd_pulse;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W-1:0] step;
  logic [CNT_W:0]    rfree;
  logic              rfit;
  logic              wr_ok, rd_ok, urgent;
  logic              grant_rd, grant_wr;
  logic              last_beat;
  logic              dpage;

  ddr_load_sync u_wr_sync (
    .clk      (clk),
    .rst_n    (sys_rst_n),
    .async_in (wr_load),
    .pulse    (wr_pulse)
  );

  ddr_load_sync u_rd_sync (
    .clk      (clk),
    .rst_n    (sys_rst_n),
    .async_in (rd_load),
    .pulse    (rd_pulse)
  );

  // Pointers are kept as offsets from min so reset lands on min.
  assign wr_ptr = app_addr_wr_min + wr_off_q;
  assign rd_ptr = app_addr_rd_min + rd_off_q;
  assign step   = ADDR_W'(len_q) * ADDR_W'(ADDR_STEP);

  assign rfree  = (CNT_W+1)'(RFIFO_DEPTH) - {1'b0, rfifo_cnt};
  assign rfit   = ({1'b0, rfifo_cnt} <= (CNT_W+1)'(RFIFO_DEPTH))
               && (rfree >= (CNT_W+1)'(rd_burst_len));

  assign wr_ok  = !wr_done_q
               && (wfifo_cnt >= CNT_W'(wr_burst_len));
  assign rd_ok  = !rd_done_q && rfit;
  assign urgent = rfifo_cnt < CNT_W'(RD_URGENT);

  assign grant_rd = rd_ok
                 && (urgent || !wr_ok || !last_rd_q);
  assign grant_wr = wr_ok && !grant_rd;

  assign last_beat = beat_q == (len_q - 8'd1);

  always_comb begin
    state_d     = state_q;
    wr_off_d    = wr_off_q;
    rd_off_d    = rd_off_q;
    wr_page_d   = wr_page_q;
    rd_page_d   = rd_page_q;
    done_page_d = done_page_q;
    wr_done_d   = wr_done_q;
    rd_done_d   = rd_done_q;
    wr_pend_d   = wr_pend_q | wr_pulse;
    rd_pend_d   = rd_pend_q | rd_pulse;
    last_rd_d   = last_rd_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    bn_d        = bn_q;
    len_d       = len_q;
    beat_d      = beat_q;
    dpage       = done_page_q;

    unique case (state_q)
      IDLE: begin
        if (wr_pend_q || rd_pend_q) begin
          if (wr_pend_q) begin
            if (wr_done_q) dpage = wr_page_q;
            wr_page_d = ~wr_page_q;
            wr_off_d  = '0;
            wr_done_d = app_addr_wr_min >= app_addr_wr_max;
            wr_pend_d = wr_pulse;
          end
          // Reader follows the page the writer just finished.
          if (rd_pend_q) begin
            rd_page_d = dpage;
            rd_off_d  = '0;
            rd_done_d = app_addr_rd_min >= app_addr_rd_max;
            rd_pend_d = rd_pulse;
          end
          done_page_d = dpage;
        end else if (init_calib_complete
                     && (grant_rd || grant_wr)) begin
          beat_d    = '0;
          last_rd_d = grant_rd;
          if (grant_rd) begin
            state_d = RD_CMD;
            cmd_d   = CMD_RD;
            addr_d  = rd_ptr + (rd_page_q ? PAGE_OFS : '0);
            len_d   = rd_burst_len;
          end else begin
            state_d = WR_CMD;
            cmd_d   = CMD_WR;
            addr_d  = wr_ptr + (wr_page_q ? PAGE_OFS : '0);
            len_d   = wr_burst_len;
          end
          bn_d = burst_num(len_d);
        end
      end
      WR_CMD: begin
        if (app.app_cmd_rdy) state_d = WR_DATA;
      end
      WR_DATA: begin
        if (app.app_wdf_rdy) begin
          beat_d = beat_q + 8'd1;
          if (last_beat) begin
            state_d   = IDLE;
            wr_off_d  = wr_off_q + step;
            wr_done_d = (wr_ptr + step) >= app_addr_wr_max;
          end
        end
      end
      RD_CMD: begin
        if (app.app_cmd_rdy) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (app.app_rd_data_valid) begin
          beat_d = beat_q + 8'd1;
          if (last_beat) begin
            state_d   = IDLE;
            rd_off_d  = rd_off_q + step;
            rd_done_d = (rd_ptr + step) >= app_addr_rd_max;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      wr_off_q    <= '0;
      rd_off_q    <= '0;
      wr_page_q   <= 1'b0;
      rd_page_q   <= 1'b0;
      done_page_q <= 1'b0;
      wr_done_q   <= 1'b0;
      rd_done_q   <= 1'b0;
      wr_pend_q   <= 1'b0;
      rd_pend_q   <= 1'b0;
      last_rd_q   <= 1'b1;
      cmd_q       <= CMD_WR;
      addr_q      <= '0;
      bn_q        <= '0;
      len_q       <= '0;
      beat_q      <= '0;
    end else begin
      state_q     <= state_d;
      wr_off_q    <= wr_off_d;
      rd_off_q    <= rd_off_d;
      wr_page_q   <= wr_page_d;
      rd_page_q   <= rd_page_d;
      done_page_q <= done_page_d;
      wr_done_q   <= wr_done_d;
      rd_done_q   <= rd_done_d;
      wr_pend_q   <= wr_pend_d;
      rd_pend_q   <= rd_pend_d;
      last_rd_q   <= last_rd_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      bn_q        <= bn_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
    end
  end

  assign app.app_cmd_en       = (state_q == WR_CMD)
                             || (state_q == RD_CMD);
  assign app.app_cmd          = cmd_q;
  assign app.app_addr         = addr_q;
  assign app.app_burst_number = bn_q;
  assign app.app_wdf_wren     = (state_q == WR_DATA)
                             && app.app_wdf_rdy;
  assign app.app_wdf_end      = app.app_wdf_wren && last_beat;
  assign wfifo_rden           = app.app_wdf_wren;
  assign wr_page              = wr_page_q;
  assign rd_page              = rd_page_q;

endmodule
